// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-file sequencer states and default widths.
package cpu_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-entry pending bits for hazard detection, with busy lookup on every read port.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 1 << REG_ADDR_W_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_a_en,
  input  logic [ADDR_W-1:0]        clr_a_addr,
  input  logic                     clr_b_en,
  input  logic [ADDR_W-1:0]        clr_b_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        busy
);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    pending_d = pending_q;
    if (clr_a_en) pending_d[clr_a_addr] = 1'b0;
    if (clr_b_en) pending_d[clr_b_addr] = 1'b0;
    // Set is applied last: a producer issued in the same cycle as a writeback stays pending.
    if (set_en)   pending_d[set_addr]   = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments; blocking is kept to combinational blocks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    logic [ADDR_W-1:0] addr;
    logic              fwd_hit;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign fwd_hit = (BYPASS != 0) &&
                     ((clr_a_en && (clr_a_addr == addr)) || (clr_b_en && (clr_b_addr == addr)));
    assign busy[k] = pending_q[addr] && !fwd_hit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports, optional
// zero register and write-to-read bypass, scoreboard, and a post-reset clear sequencer.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 1 << REG_ADDR_W_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ready_o,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wa_en_i,
  input  logic [ADDR_W-1:0]        wa_addr_i,
  input  logic [DATA_W-1:0]        wa_data_i,
  input  logic                     wb_en_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready;
  logic              wa_we;
  logic              wb_we;
  logic              alloc_we;
  logic [NUM_RD-1:0] sb_busy;

  assign ready   = (state_q == READY);
  assign ready_o = ready;

  // Effective enables: dropped while clearing and, with a zero register, when aimed at entry 0.
  assign wa_we    = ready && wa_en_i    && !((ZERO_REG != 0) && (wa_addr_i    == '0));
  assign wb_we    = ready && wb_en_i    && !((ZERO_REG != 0) && (wb_addr_i    == '0));
  assign alloc_we = ready && alloc_en_i && !((ZERO_REG != 0) && (alloc_addr_i == '0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_ADDR) state_q <= READY;
    end
  end

  // NOTE: the storage array has no reset so it can map onto RAM; the clear sequencer zeroes it.
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wa_we) mem[wa_addr_i] <= wa_data_i;
      if (wb_we) mem[wb_addr_i] <= wb_data_i;
    end
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en     (alloc_we),
    .set_addr   (alloc_addr_i),
    .clr_a_en   (wa_we),
    .clr_a_addr (wa_addr_i),
    .clr_b_en   (wb_we),
    .clr_b_addr (wb_addr_i),
    .rd_addr    (rd_addr_i),
    .busy       (sb_busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic              zero_hit;

    assign addr     = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);

    // Port B is checked after port A so its data wins when both hit.
    always_comb begin
      word = mem[addr];
      if (BYPASS != 0) begin
        if (wa_we && (wa_addr_i == addr)) word = wa_data_i;
        if (wb_we && (wb_addr_i == addr)) word = wb_data_i;
      end
      if (!ready || zero_hit) word = '0;
    end

    assign rd_data_o[k*DATA_W +: DATA_W] = word;
    assign rd_busy_o[k]                  = ready && sb_busy[k] && !zero_hit;
  end

endmodule
